// File: rtl/fir_fold_ctrl.sv
// fir_fold_ctrl: folded 10-tap FIR sharing one multiplier and accumulator across all taps
module fir_fold_ctrl #(
  parameter int NTAPS = 10,
  parameter int XW = 4,
  parameter int CW = 4,
  parameter int YW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic          cfg_we,
  input  logic [3:0]    cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] out_y,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t state;
  logic [3:0] k;
  logic [YW-1:0] acc;
  logic [XW-1:0] d [NTAPS];
  logic [CW-1:0] c [NTAPS];
  logic [XW+CW-1:0] prod;
  logic [YW-1:0] sum;
  assign prod = (XW+CW)'(c[k]) * (XW+CW)'(d[k]);
  assign sum = acc + YW'(prod);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k <= '0;
      acc <= '0;
      out_y <= '0;
      cfg_err <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && (state != IDLE || cfg_addr >= 4'(NTAPS));
      if (cfg_we && state == IDLE && cfg_addr < 4'(NTAPS))
        c[cfg_addr] <= cfg_data;
      case (state)
        IDLE: if (in_valid) begin
          d[0] <= in_x;
          for (int i = 1; i < NTAPS; i++)
            d[i] <= d[i-1];
          acc <= '0;
          k <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= sum;
          k <= k + 4'd1;
          if (k == 4'(NTAPS-1)) begin
            out_y <= sum;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_fold_ctrl.sv
// tb_fir_fold_ctrl: randomized self-checking bench against a sum-of-products reference model
module tb_fir_fold_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_ready;
  logic [3:0] in_x = 0;
  logic cfg_we = 0;
  logic [3:0] cfg_addr = 0;
  logic [3:0] cfg_data = 0;
  logic cfg_err;
  logic out_valid;
  logic out_ready = 0;
  logic [11:0] out_y;
  logic busy;
  int n_chk = 0;
  int n_pass = 0;
  int coef [10];
  int hist [$];
  int y;
  fir_fold_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int model();
    int s = 0;
    for (int i = 0; i < 10; i++) s += coef[i] * hist[i];
    return s;
  endfunction
  task automatic clear_model();
    for (int i = 0; i < 10; i++) coef[i] = 0;
    hist = {};
    repeat (10) hist.push_back(0);
  endtask
  task automatic cfg_write(input int a, input int v);
    cfg_we = 1;
    cfg_addr = a[3:0];
    cfg_data = v[3:0];
    tick();
    cfg_we = 0;
    if (a < 10) coef[a] = v;
    check("cfg_err", cfg_err, int'(a >= 10));
  endtask
  task automatic send(input int x, input int hold, input bit mac_wr, input bit same_wr,
                      input int wa, input int wv, output int yo);
    int n;
    int y0;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1;
    in_x = x[3:0];
    cfg_we = same_wr;
    cfg_addr = wa[3:0];
    cfg_data = wv[3:0];
    tick();
    in_valid = 0;
    cfg_we = 0;
    if (same_wr && wa < 10) coef[wa] = wv;
    hist.push_front(x);
    void'(hist.pop_back());
    check("busy_mac", busy, 1);
    check("in_ready_mac", in_ready, 0);
    check("cfg_err_accept", cfg_err, int'(same_wr && wa >= 10));
    n = 0;
    while (!out_valid && n < 50) begin
      cfg_we = mac_wr && n == 2;
      cfg_addr = 0;
      cfg_data = 7;
      tick();
      n++;
      cfg_we = 0;
      if (mac_wr && n == 3) check("cfg_err_mac", cfg_err, 1);
      if (mac_wr && n == 4) check("cfg_err_pulse", cfg_err, 0);
    end
    check("latency", n, 10);
    check("out_y", int'(out_y), model());
    y0 = int'(out_y);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1;
      in_x = 4'($urandom_range(0, 15));
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_y", int'(out_y), y0);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    check("out_valid_drop", out_valid, 0);
    yo = y0;
  endtask
  initial begin
    clear_model();
    repeat (2) tick();
    reset = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    for (int i = 0; i < 10; i++) cfg_write(i, i + 1);
    for (int i = 0; i < 10; i++) begin
      send(i == 0 ? 1 : 0, 0, 0, 0, 0, 0, y);
      check("impulse", y, i + 1);
    end
    send(0, 0, 0, 0, 0, 0, y);
    check("impulse_tail", y, 0);
    for (int i = 0; i < 10; i++) cfg_write(i, 15);
    for (int i = 0; i < 10; i++) begin
      send(15, 0, 0, 0, 0, 0, y);
      check("fullscale", y, 225 * (i + 1));
    end
    send(3, 5, 0, 0, 0, 0, y);
    cfg_write(0, 2);
    send(6, 0, 1, 0, 0, 0, y);
    cfg_write(12, 9);
    tick();
    check("cfg_err_one_cycle", cfg_err, 0);
    send(11, 0, 0, 0, 0, 0, y);
    repeat (30) begin
      repeat ($urandom_range(0, 2)) cfg_write($urandom_range(0, 15), $urandom_range(0, 15));
      send($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15), y);
    end
    cfg_write(0, 15);
    send(15, 0, 0, 0, 0, 0, y);
    in_valid = 1;
    in_x = 7;
    tick();
    in_valid = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    clear_model();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_y", int'(out_y), 0);
    send(9, 0, 0, 0, 0, 0, y);
    check("zero_coef", y, 0);
    send(5, 0, 0, 1, 0, 3, y);
    check("same_cycle", y, 15);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_fold_ctrl.md
# fir_fold_ctrl

Folded 10-tap FIR controller: shares one constant-free 4×4 multiplier and one accumulator across all taps instead of ten per-tap multipliers plus an adder tree. Accepts 4-bit samples over a valid/ready handshake and keeps a 10-deep sample delay line. Holds a run-time-programmable coefficient bank. Sequences one multiply-accumulate per tap per clock and presents the 12-bit filter output over a valid/ready handshake. Sits between the sample source and the downstream result consumer.

## Interface
- NTAPS, 10, number of taps (delay-line depth and coefficient count)
- XW, 4, sample width (unsigned)
- CW, 4, coefficient width (unsigned)
- YW, 12, output width; must be ≥ XW+CW+ceil(log2(NTAPS))

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  in  1  sample present on in_x
- in_ready  out  1  block can accept a sample this cycle
- in_x  in  XW  input sample
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  4  coefficient index 0..NTAPS-1
- cfg_data  in  CW  coefficient value
- cfg_err  out  1  one-cycle pulse: the preceding cfg_we was dropped
- out_valid  out  1  out_y holds a completed result
- out_ready  in  1  consumer takes the result this cycle
- out_y  out  YW  filter output
- busy  out  1  high in MAC and DONE

## Operation
- States: IDLE, MAC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: shift the delay line (d[0]←in_x, d[k]←d[k-1]), acc←0, tap counter k←0, go to MAC.
- **MAC**
  - Each cycle: acc←acc + c[k]·d[k], k←k+1.
  - After the k=NTAPS-1 update, go to DONE.
- **DONE**
  - out_valid=1, out_y=acc, held stable.
  - When out_ready=1: go to IDLE, out_valid drops next cycle.
- **Output formula**
  - Result = Σ c[k]·d[k], k=0..NTAPS-1.
  - d[0] is the newest sample.
- **Arithmetic**
  - Products are XW+CW = 8 bits, zero-extended to YW.
  - Maximum sum is 10·15·15 = 2250, so overflow cannot occur.
- **Coefficient writes**
  - Taken only in IDLE and only when cfg_addr < NTAPS: c[cfg_addr]←cfg_data.
  - A write attempted in MAC or DONE is dropped: no state change, cfg_err pulses the next cycle.
  - A write with cfg_addr ≥ NTAPS is dropped the same way.
- **Same-cycle write and sample in IDLE**
  - Both actions happen.
  - The new coefficient is used in that sample's MAC pass.
- in_valid while not in IDLE: ignored (in_ready=0); the sample stays with the source.
- **Reset**
  - Outputs after reset: in_ready=1, out_valid=0, out_y=0, busy=0, cfg_err=0.
  - State returns to IDLE.
  - Cleared to 0: acc, k, all d[k] and all c[k].
  - Reset mid-MAC or in DONE discards the pending result.
  - Reset has priority over every other event.

## Timing
- Acceptance edge E0 (in_valid & in_ready).
- MAC updates occur on edges E1..E10.
- out_valid is high from the cycle after E10: 10 cycles of latency, edge to valid.
- With out_ready held high, DONE lasts 1 cycle and IDLE is re-entered after E11.
- The next acceptance is possible at E12, giving a minimum sample period of 12 cycles.
- out_y changes only on the edge entering DONE.
- busy = (state ≠ IDLE), derived from registered state.
- in_ready = (state == IDLE), derived from registered state.
- cfg_err is registered: high exactly one cycle, on the cycle after the dropped strobe.

## Test plan
- **Impulse response:** reset; write c[k]=k+1 for k=0..9; push 1 then nine 0s → out_y sequence 1,2,3,…,10; an 11th sample (0) → 0.
- **Full-scale:** all c=15; push ten samples of 15 → tenth out_y = 2250 (0x8CA); earlier outputs 225, 450, …, 2025.
- **Latency and backpressure:**
  - out_valid rises exactly 10 cycles after the acceptance edge.
  - With out_ready held low 5 cycles, out_valid and out_y stay constant and in_ready=0 throughout.
  - One result is consumed when out_ready rises.
- **Illegal configuration:**
  - cfg_we during MAC (addr 0, data 7) → cfg_err pulses 1 cycle; the result is unchanged from the golden model using the old c[0].
  - cfg_we in IDLE with cfg_addr=12 → cfg_err pulse; no coefficient changes.
- **Reset mid-operation:**
  - Assert reset on the 5th MAC cycle → next cycle in_ready=1, out_valid=0, busy=0, out_y=0.
  - Afterwards, a sample of 9 with all c=0 gives out_y=0.
- **Same-cycle write and sample in IDLE:** c all 0; in one IDLE cycle write c[0]=3 and push x=5 → out_y=15.
